uart_fifo_transceiver: RTL
==========================

Name: uart_fifo_transceiver

Overview:
Parametrised full-duplex UART: a transmitter with a TX FIFO and a mid-bit-sampling receiver with a held-output handshake, in one clock domain. It generalises the single-byte async transmitter/receiver pair to configurable data width, bit period, stop bits and FIFO depth. It adds frame-error, false-start and overrun handling. It sits between the host/filter datapath and the board serial pins.

Parameters:
CLK_PER_BIT, 16, clock cycles per serial bit; even, >=4
DATA_W, 8, data bits per frame; 5..9
TX_DEPTH, 4, TX FIFO entries; power of 2, >=2
STOP_BITS, 1, stop bits transmitted; 1 or 2 (RX always checks one)
PARITY_ODD, 0, parity sense when parity is compiled in; 0 = even, 1 = odd

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
tx_valid  in  1  host offers tx_data
tx_data  in  DATA_W  byte to send
tx_ready  out  1  FIFO not full; write occurs when tx_valid && tx_ready
tx_busy  out  1  FIFO non-empty or TX FSM not IDLE
txd  out  1  serial out; idle high
rxd  in  1  serial in; asynchronous
rx_valid  out  1  rx_data holds an unread frame
rx_ready  in  1  host consumes; clears rx_valid when rx_valid && rx_ready
rx_data  out  DATA_W  received data, LSB first on the wire
rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
rx_overrun  out  1  one-cycle pulse: frame completed while rx_valid high
rx_parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 without the macro)

Behaviour:
- Reset (rst=0, async): txd=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, all error pulses 0.
- Reset also empties the FIFO, sends both FSMs to IDLE, clears all counters, and sets the synchroniser flops to 1.
- Reset mid-frame aborts the frame immediately; txd returns high in the same instant.
- TX FIFO:
  - Write on tx_valid && tx_ready.
  - tx_ready = !full, registered from the occupancy count.
  - Write while full is ignored.
  - Simultaneous write and pop when full is not permitted, because tx_ready=0.
  - Simultaneous write and pop at any other level keeps the count unchanged.
- TX FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE pops the FIFO head into the shift register when non-empty.
  - Latency: a write at edge N into an empty FIFO drives txd low at edge N+2.
  - Every bit is held exactly CLK_PER_BIT cycles.
  - Frame order: start bit (0), DATA_W data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
  - After the last stop bit, a non-empty FIFO starts the next start bit on the next cycle, with no idle gap.
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - IDLE: a synchronised low starts the baud counter.
  - START: re-sample after CLK_PER_BIT/2 cycles. A high sample is a false start; return to IDLE with no outputs.
  - DATA: sample every CLK_PER_BIT cycles, DATA_W bits, shifting LSB first.
  - PARITY (macro only): one more sample.
  - STOP: one sample, then return to IDLE on the next cycle, ready to detect a start bit from mid-stop onward.
- RX completion, decided on the cycle after the stop sample:
  - Stop bit low: pulse rx_frame_err; rx_data and rx_valid unchanged.
  - Else, parity bad: pulse rx_parity_err; frame dropped.
  - Else, rx_valid=1: pulse rx_overrun; rx_data keeps the old frame and the new one is dropped.
  - Else: load rx_data and set rx_valid=1.
  - rx_ready with rx_valid clears rx_valid next edge. If the clear coincides with a new completion, the new frame loads and rx_valid stays 1 (no overrun).

Optional Feature:
UART_PARITY_EN
- Defined: TX inserts a parity bit after the data bits. The bit is XOR of the data for even parity, inverted when PARITY_ODD=1. RX checks it and drives rx_parity_err.
- Undefined: no parity bit in either direction; rx_parity_err tied 0. Frame length is 1+DATA_W+STOP_BITS bits.

Test Plan:
- Loopback (txd->rxd), defaults: write 0xD5 at edge N -> txd falls at N+2, frame lasts 160 cycles, rx_valid rises with rx_data=0xD5, no error pulses.
- Burst: 6 back-to-back writes 0x01..0x06 with rx_ready=1 -> tx_ready drops when the FIFO holds 4 entries, no write is lost once the handshake is respected, frames go out with zero idle cycles, and RX delivers 0x01..0x06 in order.
- Frame error: drive rxd with 0x8C and the stop bit held low -> one rx_frame_err pulse, rx_valid stays 0.
- False start: 4-cycle low glitch on rxd -> no rx_valid, RX back in IDLE; a following 0x3A frame is received correctly.
- Overrun: receive 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, one rx_overrun pulse; then assert rx_ready for 1 cycle -> rx_valid=0.
- Reset mid-frame: pull rst low during bit 3 of 0xFF -> txd=1 immediately, tx_busy=0, FIFO empty; after release a write of 0x5A transmits cleanly. With UART_PARITY_EN and PARITY_ODD=0, 0x5A carries parity bit 0.

Source files
------------

// File: rtl/uart_fifo_transceiver.sv
// Full-duplex UART: TX FIFO + framed transmitter, mid-bit-sampling receiver with held output.
// Optional parity in both directions is compiled in with `define UART_PARITY_EN.
module uart_fifo_transceiver #(
   parameter int CLK_PER_BIT = 16,
   parameter int DATA_W      = 8,
   parameter int TX_DEPTH    = 4,
   parameter int STOP_BITS   = 1,
   parameter bit PARITY_ODD  = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx_busy,
   output logic              txd,
   input  logic              rxd,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_frame_err,
   output logic              rx_overrun,
   output logic              rx_parity_err
);

   localparam int CW = $clog2(CLK_PER_BIT);
   localparam int AW = $clog2(TX_DEPTH);
   localparam int BW = $clog2(DATA_W + 1);

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(TX_DEPTH);

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_t;

   // ---------------------------------------------------------------- TX FIFO
   logic [DATA_W-1:0] tx_mem [TX_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       tx_count;
   logic [AW:0]       count_next;
   logic              tx_wr;
   logic              tx_pop;
   logic              tx_last_stop;

   assign tx_wr = tx_valid && tx_ready;

   // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      count_next = tx_count;
      if (tx_wr && !tx_pop)
         count_next = tx_count + 1'b1;
      else if (!tx_wr && tx_pop)
         count_next = tx_count - 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_count <= '0;
         tx_ready <= 1'b1;
      end else begin
         if (tx_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (tx_pop)
            rd_ptr <= rd_ptr + 1'b1;
         tx_count <= count_next;
         tx_ready <= (count_next != DEPTH_CNT);
      end
   end

   // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (tx_wr)
         tx_mem[wr_ptr] <= tx_data;
   end

   // ---------------------------------------------------------------- TX FSM
   tx_state_t         tx_state;
   logic [DATA_W-1:0] tx_shift;
   logic [CW-1:0]     tx_cnt;
   logic [BW-1:0]     tx_bit;
`ifdef UART_PARITY_EN
   logic              tx_par;
`endif

   assign tx_last_stop = (tx_state == TX_STOP) && (tx_cnt == BIT_LAST) && (tx_bit == STOP_LAST);
   // The head is popped from IDLE or straight out of the last stop bit, giving gapless bursts.
   assign tx_pop  = (tx_count != '0) && ((tx_state == TX_IDLE) || tx_last_stop);
   assign tx_busy = (tx_count != '0) || (tx_state != TX_IDLE);

   // txd is registered from the state, so the line lags the state by one cycle throughout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state <= TX_IDLE;
         tx_shift <= '0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         txd      <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         case (tx_state)
            TX_IDLE: begin
               txd    <= 1'b1;
               tx_cnt <= '0;
               tx_bit <= '0;
               if (tx_pop) begin
                  tx_shift <= tx_mem[rd_ptr];
`ifdef UART_PARITY_EN
                  tx_par   <= (^tx_mem[rd_ptr]) ^ PARITY_ODD;
`endif
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               txd <= 1'b0;
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               txd <= tx_shift[0];
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_shift <= tx_shift >> 1;
                  if (tx_bit == DATA_LAST) begin
                     tx_bit   <= '0;
`ifdef UART_PARITY_EN
                     tx_state <= TX_PARITY;
`else
                     tx_state <= TX_STOP;
`endif
                  end else begin
                     tx_bit <= tx_bit + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
               txd <= tx_par;
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_STOP;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
`endif
            TX_STOP: begin
               txd <= 1'b1;
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == STOP_LAST) begin
                     tx_bit <= '0;
                     if (tx_pop) begin
                        tx_shift <= tx_mem[rd_ptr];
`ifdef UART_PARITY_EN
                        tx_par   <= (^tx_mem[rd_ptr]) ^ PARITY_ODD;
`endif
                        tx_state <= TX_START;
                     end else begin
                        tx_state <= TX_IDLE;
                     end
                  end else begin
                     tx_bit <= tx_bit + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: begin
               txd      <= 1'b1;
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- RX path
   logic [1:0]        rx_sync;
   logic              rx_s;
   rx_state_t         rx_state;
   logic [CW-1:0]     rx_cnt;
   logic [BW-1:0]     rx_bit;
   logic [DATA_W-1:0] rx_shift;
   logic              rx_done;
   logic              rx_stop_ok;
`ifdef UART_PARITY_EN
   logic              rx_par_ok;
`else
   assign rx_parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rx_sync <= 2'b11;
      else
         rx_sync <= {rx_sync[0], rxd};
   end

   assign rx_s = rx_sync[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         rx_done      <= 1'b0;
         rx_stop_ok   <= 1'b1;
         rx_valid     <= 1'b0;
         rx_data      <= '0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_ok     <= 1'b1;
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_done      <= 1'b0;
`ifdef UART_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         // A consume on the same cycle frees the holding register, so that case loads, not overruns.
         if (rx_done) begin
            if (!rx_stop_ok)
               rx_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
            else if (!rx_par_ok)
               rx_parity_err <= 1'b1;
`endif
            else if (rx_valid && !rx_ready)
               rx_overrun <= 1'b1;
            else begin
               rx_data  <= rx_shift;
               rx_valid <= 1'b1;
            end
         end

         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               rx_bit <= '0;
               if (!rx_s)
                  rx_state <= RX_START;
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s, rx_shift[DATA_W-1:1]};
                  if (rx_bit == DATA_LAST) begin
                     rx_bit   <= '0;
`ifdef UART_PARITY_EN
                     rx_state <= RX_PARITY;
`else
                     rx_state <= RX_STOP;
`endif
                  end else begin
                     rx_bit <= rx_bit + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt    <= '0;
                  rx_par_ok <= ((^rx_shift) ^ rx_s) == PARITY_ODD;
                  rx_state  <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt     <= '0;
                  rx_stop_ok <= rx_s;
                  rx_done    <= 1'b1;
                  rx_state   <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule
